// File: rtl/iir_coef_loader.sv
// Streams scale and coefficient words into an IIR filter's memories.
// Word order: scale[0], then per section six coefficients followed by the next scale word.
module iir_coef_loader #(
    parameter  int NUMBER  = 4,
    parameter  int TAPSIZE = 3,
    parameter  int WIS     = 5,
    parameter  int WFS     = 11,
    localparam int AW      = $clog2(TAPSIZE*2*NUMBER),
    localparam int W       = WIS + WFS
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [W-1:0]  s_data,
    output logic          s_ready,
    output logic          wr_en,
    output logic          wr_sel,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  wr_data,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int SW = $clog2(NUMBER + 1);
    localparam int TW = (2*TAPSIZE > 1) ? $clog2(2*TAPSIZE) : 1;

    typedef enum logic [1:0] {IDLE, SCALE, COEF, DONE} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] sec, sec_nxt;
    logic [TW-1:0] tap, tap_nxt;
    logic          accept;
    logic [AW-1:0] coef_addr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            sec   <= '0;
            tap   <= '0;
        end else begin
            state <= state_nxt;
            sec   <= sec_nxt;
            tap   <= tap_nxt;
        end
    end

    // s_ready is a pure state decode, so acceptance never depends combinationally on itself
    assign accept = s_valid && s_ready && !abort;

    always_comb begin
        state_nxt = state;
        sec_nxt   = sec;
        tap_nxt   = tap;
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
            sec_nxt   = '0;
            tap_nxt   = '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state_nxt = SCALE;
                    sec_nxt   = '0;
                    tap_nxt   = '0;
                end
                SCALE: if (accept) begin
                    state_nxt = (sec == SW'(NUMBER)) ? DONE : COEF;
                    tap_nxt   = '0;
                end
                COEF: if (accept) begin
                    if (tap == TW'(2*TAPSIZE - 1)) begin
                        state_nxt = SCALE;
                        sec_nxt   = sec + 1'b1;
                        tap_nxt   = '0;
                    end else begin
                        tap_nxt = tap + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        s_ready = (state == SCALE) || (state == COEF);
        busy    = s_ready;
        done    = (state == DONE);
    end

    assign coef_addr = AW'(32'(sec) * (2*TAPSIZE)) + AW'(tap);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_en   <= 1'b0;
            wr_sel  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            err     <= 1'b0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_sel  <= (state == COEF);
                wr_addr <= (state == COEF) ? coef_addr : AW'(sec);
                wr_data <= s_data;
            end
            err <= (start && busy && !abort) ||
                   (s_valid && (state == IDLE || state == DONE));
        end
    end

endmodule

// File: tb/tb_iir_coef_loader.sv
// Directed bench for iir_coef_loader with default parameters (29-word load).
module tb_iir_coef_loader;
    logic        CLK = 1'b0;
    logic        RST;
    logic        start, abort, s_valid;
    logic [15:0] s_data;
    logic        s_ready, wr_en, wr_sel, busy, done, err;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int ncmp = 0;
    int nerr = 0;

    logic       lsel  [0:255];
    logic [4:0] laddr [0:255];
    logic [15:0] ldata[0:255];
    logic       ldone [0:255];
    int         wcnt = 0;

    iir_coef_loader dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    // Write log, sampled mid-cycle so each one-cycle strobe is recorded once
    always @(negedge CLK) begin
        if (wr_en && wcnt < 256) begin
            lsel[wcnt]  <= wr_sel;
            laddr[wcnt] <= wr_addr;
            ldata[wcnt] <= wr_data;
            ldone[wcnt] <= done;
            wcnt        <= wcnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Word p (0-based) of a load: every 7th is a scale word, the rest are section coefficients
    task automatic check_seq(input int base, input string tag);
        int bad = 0;
        for (int i = 0; i < 29; i++) begin
            logic       es;
            logic [4:0] ea;
            es = (i % 7) != 0;
            ea = es ? 5'((i / 7) * 6 + (i % 7) - 1) : 5'(i / 7);
            if (lsel[base+i] !== es || laddr[base+i] !== ea || ldata[base+i] !== 16'(i + 1))
                bad++;
        end
        chk(tag, 32'(bad), 0);
    endtask

    task automatic send(input logic [15:0] v);
        s_valid = 1'b1;
        s_data  = v;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int base;
        int bad;
        RST = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
        tick(); tick();
        chk("rst_ready", s_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy_done_err", {busy, done, err}, 0);
        chk("rst_addr_data", {wr_sel, wr_addr, wr_data}, 0);
        RST = 1'b0;
        tick();

        // Full back-to-back load
        base = wcnt;
        do_start();
        chk("start_busy_ready", {busy, s_ready, done}, 3'b110);
        s_valid = 1'b1;
        for (int n = 1; n <= 29; n++) begin
            s_data = 16'(n);
            tick();
        end
        s_valid = 1'b0;
        chk("full_last_wr_en", wr_en, 1);
        chk("full_done_busy", {done, busy, s_ready}, 3'b100);
        tick();
        chk("full_wr_en_drop", wr_en, 0);
        chk("full_count", 32'(wcnt - base), 29);
        chk("full_w1", {lsel[base], laddr[base], ldata[base]}, {1'b0, 5'd0, 16'h0001});
        chk("full_w2", {lsel[base+1], laddr[base+1], ldata[base+1]}, {1'b1, 5'd0, 16'h0002});
        chk("full_w7", {lsel[base+6], laddr[base+6]}, {1'b1, 5'd5});
        chk("full_w8", {lsel[base+7], laddr[base+7]}, {1'b0, 5'd1});
        chk("full_w29", {lsel[base+28], laddr[base+28], ldata[base+28]}, {1'b0, 5'd4, 16'h001D});
        chk("full_done_with_last", ldone[base+28], 1);
        chk("full_no_early_done", ldone[base+27], 0);
        check_seq(base, "full_seq");
        tick();
        chk("done_sticky", done, 1);

        // Gapped input: wr_en must follow accepted words only
        base = wcnt;
        do_start();
        chk("restart_clears_done", done, 0);
        bad = 0;
        for (int n = 1; n <= 29; n++) begin
            send(16'(n));
            if (wr_en !== 1'b1) bad++;
            s_data = 16'hDEAD;
            tick();
            if (wr_en !== 1'b0) bad++;
        end
        chk("gap_strobe_timing", 32'(bad), 0);
        chk("gap_count", 32'(wcnt - base), 29);
        check_seq(base, "gap_seq");
        chk("gap_done", done, 1);

        // Abort after word 10, with an 11th word offered on the abort cycle
        base = wcnt;
        do_start();
        for (int n = 1; n <= 10; n++) send(16'(n));
        s_valid = 1'b1; s_data = 16'h0055; abort = 1'b1;
        tick();
        s_valid = 1'b0; abort = 1'b0;
        chk("abort_no_wr", wr_en, 0);
        chk("abort_state", {busy, s_ready, done}, 0);
        tick(); tick();
        chk("abort_count", 32'(wcnt - base), 10);
        chk("abort_err_quiet", err, 0);

        // Start mid-load is an error and is otherwise ignored
        base = wcnt;
        do_start();
        for (int n = 1; n <= 4; n++) send(16'(n));
        start = 1'b1;
        send(16'd5);
        start = 1'b0;
        chk("start_busy_err", err, 1);
        send(16'd6);
        chk("start_busy_err_pulse", err, 0);
        for (int n = 7; n <= 29; n++) send(16'(n));
        chk("start_busy_done", done, 1);
        tick();
        chk("start_busy_count", 32'(wcnt - base), 29);
        check_seq(base, "start_busy_seq");

        // s_valid while idle
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_from_done", done, 0);
        base = wcnt;
        send(16'h7FFF);
        chk("idle_valid_err", err, 1);
        chk("idle_valid_ready", s_ready, 0);
        tick();
        chk("idle_valid_err_pulse", err, 0);
        chk("idle_valid_no_wr", 32'(wcnt - base), 0);

        // Asynchronous reset mid-load, then a clean reload
        do_start();
        for (int n = 1; n <= 14; n++) send(16'(n));
        s_valid = 1'b1; s_data = 16'd15;
        #2 RST = 1'b1;
        #1;
        chk("arst_outputs", {s_ready, wr_en, wr_sel, wr_addr, wr_data, busy, done, err}, 0);
        s_valid = 1'b0;
        tick();
        RST = 1'b0;
        base = wcnt;
        tick(); tick(); tick();
        chk("arst_no_wr_after", 32'(wcnt - base), 0);
        chk("arst_idle", {busy, s_ready}, 0);
        do_start();
        for (int n = 1; n <= 29; n++) send(16'(n));
        chk("reload_done", done, 1);
        tick();
        chk("reload_count", 32'(wcnt - base), 29);
        check_seq(base, "reload_seq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
